// File: rtl/if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pipe
// Purpose  : Fetch-to-decode pipeline register with a valid/ready handshake,
//            a one-entry skid buffer, synchronous flush with bubble insertion
//            and a saturating stall-cycle counter. All outputs are registered
//            or decoded from registered state only.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active low
//            flush      synchronous flush, discards held and incoming entries
//            if_valid   fetch presents if_pc/if_inst
//            if_ready   block can accept a fetch beat
//            if_pc      fetched PC            [ADDR_W]
//            if_inst    fetched instruction   [INST_W]
//            id_valid   id_pc/id_inst hold a valid entry
//            id_ready   decode consumes the presented entry
//            id_pc      PC to decode          [ADDR_W]
//            id_inst    instruction to decode [INST_W]
//            stall_cnt  cycles with id_valid & !id_ready, saturating [CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module if_id_pipe #(
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EMPTY: nothing held; BUSY: main valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_main_pc;
  logic [INST_W-1:0]   r_main_inst;
  logic [ADDR_W-1:0]   r_skid_pc;
  logic [INST_W-1:0]   r_skid_inst;
  logic [CNT_W-1:0]    r_stall_cnt;

  // One-hot selects for what the main/skid registers capture this edge.
  logic                w_load_main_if;
  logic                w_load_main_skid;
  logic                w_load_bubble;
  logic                w_load_skid;
  logic                w_clear_skid;
  logic                w_stall;

  // --------------------------------------------------------------------------
  // Next-state and load-select decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_if   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_bubble    = 1'b0;
    w_load_skid      = 1'b0;
    w_clear_skid     = 1'b0;

    if (flush) begin
      // Flush overrides every transition, including a beat accepted this cycle.
      w_state_nxt   = EMPTY;
      w_load_bubble = 1'b1;
      w_clear_skid  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (if_valid) begin
            w_load_main_if = 1'b1;
            w_state_nxt    = BUSY;
          end
        end
        BUSY: begin
          if (if_valid && id_ready) begin
            w_load_main_if = 1'b1;
          end else if (if_valid) begin
            // Decoder stalled: park the new beat so it is not lost.
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (id_ready) begin
            w_load_bubble = 1'b1;
            w_state_nxt   = EMPTY;
          end
        end
        FULL: begin
          if (id_ready) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = BUSY;
          end
        end
        default: begin
          w_load_bubble = 1'b1;
          w_clear_skid  = 1'b1;
          w_state_nxt   = EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Main (output) register: bubble whenever the stage is empty
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_pc   <= '0;
      r_main_inst <= BUBBLE_INST;
    end else if (w_load_bubble) begin
      r_main_pc   <= '0;
      r_main_inst <= BUBBLE_INST;
    end else if (w_load_main_if) begin
      r_main_pc   <= if_pc;
      r_main_inst <= if_inst;
    end else if (w_load_main_skid) begin
      r_main_pc   <= r_skid_pc;
      r_main_inst <= r_skid_inst;
    end
  end

  // --------------------------------------------------------------------------
  // Skid register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (w_clear_skid) begin
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (w_load_skid) begin
      r_skid_pc   <= if_pc;
      r_skid_inst <= if_inst;
    end
  end

  // --------------------------------------------------------------------------
  // Stall counter: deliberately ignores flush, only reset clears it
  // --------------------------------------------------------------------------
  assign w_stall = (r_state != EMPTY) && !id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign id_valid  = (r_state != EMPTY);
  assign if_ready  = (r_state != FULL);
  assign id_pc     = r_main_pc;
  assign id_inst   = r_main_inst;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_pipe
// Purpose  : Self-checking bench for if_id_pipe. Directed scenarios plus a
//            randomized run compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe;

  localparam int          ADDR_W  = 32;
  localparam int          INST_W  = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] BUB     = 32'h0000_0013;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              if_valid = 1'b0;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc = '0;
  logic [INST_W-1:0] if_inst = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: FIFO of held entries (capacity 2) plus stall count.
  logic [63:0] m_q[$];
  int          m_cnt = 0;

  if_id_pipe #(
    .ADDR_W     (ADDR_W),
    .INST_W     (INST_W),
    .BUBBLE_INST(BUB),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit held_valid = (m_q.size() > 0);
    bit can_take   = (m_q.size() < 2);
    if (held_valid && !id_ready && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      m_q.delete();
    end else begin
      if (held_valid && id_ready) void'(m_q.pop_front());
      if (if_valid && can_take) m_q.push_back({if_pc, if_inst});
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_q.delete();
    m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %b exp 0", id_valid); else n_pass++;
    n_chk++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready got %b exp 1", if_ready); else n_pass++;
    n_chk++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got %h exp 0", id_pc); else n_pass++;
    n_chk++; if (id_inst !== BUB) $display("FAIL reset_id_inst got %h exp %h", id_inst, BUB); else n_pass++;
    n_chk++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] ins [3] = '{32'h11, 32'h22, 32'h33};
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_pc = pcs[i]; if_inst = ins[i];
      tick();
      n_chk++; if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_inst !== ins[i])
        $display("FAIL stream_beat%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, id_valid, id_pc, id_inst, pcs[i], ins[i]);
      else n_pass++;
      n_chk++; if (if_ready !== 1'b1) $display("FAIL stream_if_ready%0d got %b exp 1", i, if_ready); else n_pass++;
    end
    if_valid = 1'b0;
    tick();
    n_chk++; if (id_valid !== 1'b0 || id_inst !== BUB) $display("FAIL stream_drain got v=%b inst=%h exp v=0 inst=%h", id_valid, id_inst, BUB); else n_pass++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'hA;
    tick();
    if_pc = 32'h104; if_inst = 32'hB;
    tick();
    n_chk++; if (if_ready !== 1'b0) $display("FAIL skid_if_ready got %b exp 0", if_ready); else n_pass++;
    n_chk++; if (id_pc !== 32'h100 || id_inst !== 32'hA) $display("FAIL skid_head got pc=%h inst=%h exp pc=100 inst=a", id_pc, id_inst); else n_pass++;
    if_valid = 1'b0; if_pc = 32'h108; if_inst = 32'hC;
    tick();
    n_chk++; if (stall_cnt !== 4'd2) $display("FAIL skid_stall_cnt got %0d exp 2", stall_cnt); else n_pass++;
    id_ready = 1'b1;
    tick();
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h104 || id_inst !== 32'hB)
      $display("FAIL skid_second got v=%b pc=%h inst=%h exp v=1 pc=104 inst=b", id_valid, id_pc, id_inst);
    else n_pass++;
    n_chk++; if (if_ready !== 1'b1) $display("FAIL skid_if_ready_rise got %b exp 1", if_ready); else n_pass++;
    tick();
    n_chk++; if (id_valid !== 1'b0) $display("FAIL skid_empty got %b exp 0", id_valid); else n_pass++;
    n_chk++; if (stall_cnt !== 4'd2) $display("FAIL skid_stall_final got %0d exp 2", stall_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'hC;
    tick();
    if_pc = 32'h204; if_inst = 32'hD;
    tick();
    flush = 1'b1; if_pc = 32'h208; if_inst = 32'hE;
    tick();
    n_chk++; if (id_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL flush_state got v=%b rdy=%b exp v=0 rdy=1", id_valid, if_ready); else n_pass++;
    n_chk++; if (id_pc !== 32'h0 || id_inst !== BUB) $display("FAIL flush_bubble got pc=%h inst=%h exp pc=0 inst=%h", id_pc, id_inst, BUB); else n_pass++;
    n_chk++; if (stall_cnt !== 4'd2) $display("FAIL flush_keeps_cnt got %0d exp 2", stall_cnt); else n_pass++;
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (id_valid !== 1'b0) $display("FAIL flush_no_resurrect%0d got v=%b pc=%h exp v=0", i, id_valid, id_pc); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'hF;
    tick();
    if_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10 || k == 15 || k == 20) begin
        n_chk++; if (stall_cnt !== 4'((k > CNT_MAX) ? CNT_MAX : k))
          $display("FAIL sat_cnt_k%0d got %0d exp %0d", k, stall_cnt, (k > CNT_MAX) ? CNT_MAX : k);
        else n_pass++;
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++; if (stall_cnt !== 4'd15) $display("FAIL sat_after_flush got %0d exp 15", stall_cnt); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'h1;
    tick();
    if_pc = 32'h404; if_inst = 32'h2;
    tick();
    if_valid = 1'b0;
    n_chk++; if (if_ready !== 1'b0 || stall_cnt !== 4'd1) $display("FAIL midrst_pre got rdy=%b cnt=%0d exp rdy=0 cnt=1", if_ready, stall_cnt); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (id_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL midrst_flags got v=%b rdy=%b exp v=0 rdy=1", id_valid, if_ready); else n_pass++;
    n_chk++; if (id_pc !== 32'h0 || id_inst !== BUB || stall_cnt !== 4'd0)
      $display("FAIL midrst_data got pc=%h inst=%h cnt=%0d exp pc=0 inst=%h cnt=0", id_pc, id_inst, stall_cnt, BUB);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    int errs = 0;
    logic [31:0] e_pc, e_inst;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      id_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 49) == 0);
      if_pc    = $urandom;
      if_inst  = $urandom;
      tick();
      e_pc   = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
      e_inst = (m_q.size() > 0) ? m_q[0][31:0]  : BUB;
      if (errs < 10) begin
        n_chk++;
        if (id_valid !== (m_q.size() > 0) || if_ready !== (m_q.size() < 2) ||
            id_pc !== e_pc || id_inst !== e_inst || stall_cnt !== 4'(m_cnt)) begin
          $display("FAIL random_cycle%0d got v=%b rdy=%b pc=%h inst=%h cnt=%0d exp v=%b rdy=%b pc=%h inst=%h cnt=%0d",
                   c, id_valid, if_ready, id_pc, id_inst, stall_cnt,
                   m_q.size() > 0, m_q.size() < 2, e_pc, e_inst, m_cnt);
          errs++;
        end else n_pass++;
      end
    end
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
